// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Latency: one cycle from PC on imem_addr to that instruction on if_instr.
// Backpressure: stall holds PC and IF/ID; flush or a taken redirect loads a bubble.
//
// Ports:
//   clk, rst             - single clock, synchronous active-high reset
//   stall, flush         - hold PC + IF/ID / squash the instruction entering IF/ID
//   branch_taken/offset  - branch redirect from decode (word offset, sign-extended)
//   jump/jump_index      - J-type redirect from decode
//   imem_addr/imem_data  - instruction memory port (combinational read)
//   if_pc/if_pc4/if_instr/if_valid - IF/ID register contents
//   fetch_count          - number of valid instructions delivered to IF/ID
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic [31:0] if_instr,
   output logic        if_valid,
   output logic [31:0] fetch_count
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_pc4_q, if_pc4_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;

   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic        redirect;

   // Targets are relative to the instruction sitting in IF/ID (the one decode is looking at).
   assign pc_plus4      = pc_q + 32'd4;
   assign jump_target   = {if_pc4_q[31:28], jump_index, 2'b00};
   assign branch_target = if_pc4_q + {branch_offset[29:0], 2'b00};
   assign redirect      = (jump | branch_taken) & ~stall;

   always_comb begin
      // Next PC: jump beats branch; a stalled cycle ignores both.
      pc_d = pc_plus4;
      if (rst) begin
         pc_d = {RESET_PC[31:2], 2'b00};
      end else if (jump & ~stall) begin
         pc_d = jump_target;
      end else if (branch_taken & ~stall) begin
         pc_d = branch_target;
      end else if (stall) begin
         pc_d = pc_q;
      end

      if_pc_d        = if_pc_q;
      if_pc4_d       = if_pc4_q;
      if_instr_d     = if_instr_q;
      if_valid_d     = if_valid_q;
      fetch_count_d  = fetch_count_q;

      if (rst) begin
         if_pc_d       = 32'h0;
         if_pc4_d      = 32'h0;
         if_instr_d    = 32'h0;
         if_valid_d    = 1'b0;
         fetch_count_d = 32'h0;
      end else if (flush | redirect) begin
         // Bubble: flush wins even over stall; PC fields keep their last value.
         if_instr_d = 32'h0;
         if_valid_d = 1'b0;
      end else if (~stall) begin
         if_instr_d    = imem_data;
         if_pc_d       = pc_q;
         if_pc4_d      = pc_plus4;
         if_valid_d    = 1'b1;
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_pc4_q      <= if_pc4_d;
      if_instr_q    <= if_instr_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
   end

   // Every PC source is word aligned, so the low bits of pc_q are always zero.
   assign imem_addr   = pc_q;
   assign if_pc       = if_pc_q;
   assign if_pc4      = if_pc4_q;
   assign if_instr    = if_instr_q;
   assign if_valid    = if_valid_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset (word aligned).
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port stall, input, 1, which holds the PC and the IF/ID register for the cycle.
REQ-005 The block SHALL have port flush, input, 1, which squashes the instruction being written into IF/ID.
REQ-006 The block SHALL have port branch_taken, input, 1, the branch redirect request from decode.
REQ-007 The block SHALL have port branch_offset, input, 32, the sign-extended word offset of the branch.
REQ-008 The block SHALL have port jump, input, 1, the jump redirect request from decode.
REQ-009 The block SHALL have port jump_index, input, 26, the J-type target field.
REQ-010 The block SHALL have port imem_addr, output, 32, the instruction memory address, equal to the current PC.
REQ-011 The block SHALL have port imem_data, input, 32, the instruction memory read data, combinational from imem_addr in the same cycle.
REQ-012 The block SHALL have port if_pc, output, 32, the PC of the instruction held in IF/ID.
REQ-013 The block SHALL have port if_pc4, output, 32, equal to if_pc+4.
REQ-014 The block SHALL have port if_instr, output, 32, the instruction held in IF/ID and consumed by the control unit and register file.
REQ-015 The block SHALL have port if_valid, output, 1, which is 1 when if_instr is a real fetched instruction.
REQ-016 The block SHALL have port fetch_count, output, 32, the number of valid instructions delivered to IF/ID.

Function
REQ-017 PC register: every cycle, the next PC SHALL be selected by priority rst > (jump & !stall) > (branch_taken & !stall) > stall > PC+4.
REQ-018 Jump target SHALL be {if_pc4[31:28], jump_index, 2'b00}.
REQ-019 Branch target SHALL be if_pc4 + (branch_offset << 2), computed mod 2^32 with carry discarded.
REQ-020 If jump and branch_taken are both asserted, the jump SHALL win.
REQ-021 PC+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-022 imem_addr[1:0] SHALL always be 2'b00.
REQ-023 IF/ID update on a cycle with stall=0 and no redirect/flush: if_instr<=imem_data, if_pc<=PC, if_pc4<=PC+4, if_valid<=1.
REQ-024 Redirect squash: on a cycle with (jump|branch_taken)&!stall, the instruction fetched that cycle SHALL be discarded (no delay slot): if_instr<=32'h0, if_valid<=0, and if_pc/if_pc4 hold.
REQ-025 flush=1 with stall=0 SHALL load the same bubble as REQ-024; the PC still advances per REQ-017.
REQ-026 stall=1 SHALL hold PC and all IF/ID outputs and ignore jump/branch_taken for that cycle; decode re-asserts the redirect once stall drops.
REQ-027 stall=1 and flush=1 together SHALL load a bubble into IF/ID (flush wins for IF/ID) while the PC holds.
REQ-028 fetch_count SHALL increment by 1 in exactly the cycles where if_valid is written as 1, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-029 Latency SHALL be one cycle: an instruction at PC appears on if_instr the cycle after PC is presented on imem_addr.

Reset
REQ-030 With rst=1 at a rising edge, the block SHALL load PC<=RESET_PC, if_instr<=0, if_pc<=0, if_pc4<=0, if_valid<=0, and fetch_count<=0.
REQ-031 rst SHALL override stall, flush, and redirects; reset asserted mid-operation SHALL discard any pending IF/ID content.
REQ-032 In the first cycle after rst deasserts, imem_addr SHALL equal RESET_PC.

Verification
REQ-033 Sequential fetch: reset, then 4 cycles with a memory returning instr=addr -> imem_addr shows 0,4,8,C; if_instr shows 0,4,8 one cycle later; if_valid=1; fetch_count=3 after the 4th edge.
REQ-034 Branch: if_pc4=32'h10 and branch_offset=32'hFFFF_FFFE with branch_taken=1 for 1 cycle -> next PC=32'h08, if_valid=0 for one cycle, and the following if_pc=32'h08.
REQ-035 Jump: if_pc4=32'h4000_0010, jump_index=26'h000_0040, jump=1 and branch_taken=1 -> next PC=32'h4000_0100.
REQ-036 Stall: stall=1 for 3 cycles at PC=32'h20 with branch_taken=1 -> PC, if_instr, and fetch_count are frozen and the redirect is ignored; after stall drops, PC=32'h24.
REQ-037 Flush+stall and wrap: stall=1 and flush=1 -> if_valid=0 and PC held. Separately, PC=32'hFFFF_FFFC with no stall -> next PC=32'h0.
REQ-038 Mid-run reset: rst=1 for one cycle while if_valid=1 and fetch_count=5 -> all outputs go to 0 and imem_addr=RESET_PC on the next cycle.
